// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, aligns store lanes, extends load data, drives mem2wb.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses become illegal instructions with no request.
module mem_stage #(
    parameter int DW  = 32,
    parameter int RFW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex2mem_valid,
    input  logic           ex2mem_reg_wen,
    input  logic [RFW-1:0] ex2mem_reg_waddr,
    input  logic [DW-1:0]  ex2mem_alu_out,
    input  logic           ex2mem_mem_rd,
    input  logic           ex2mem_mem_wr,
    input  logic [2:0]     ex2mem_mem_funct3,
    input  logic [DW-1:0]  ex2mem_mem_wdata,
    input  logic           ex2mem_ill_instr,
    output logic           dmem_req,
    output logic           dmem_write,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    output logic [3:0]     dmem_byte_en,
    input  logic           dmem_ready,
    input  logic           dmem_rvalid,
    input  logic [DW-1:0]  dmem_rdata,
    output logic           mem_stall,
    output logic           mem2wb_reg_wen,
    output logic [RFW-1:0] mem2wb_reg_waddr,
    output logic [DW-1:0]  mem2wb_reg_wdata,
    output logic           mem2wb_ill_instr
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state_q, state_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [1:0]     off_q, off_d;
    logic [RFW-1:0] ld_waddr_q, ld_waddr_d;
    logic           ld_wen_q, ld_wen_d;
    logic           wb_wen_q, wb_wen_d;
    logic [RFW-1:0] wb_waddr_q, wb_waddr_d;
    logic [DW-1:0]  wb_wdata_q, wb_wdata_d;
    logic           wb_ill_q, wb_ill_d;

    logic          raw_mem_op, misaligned, mem_op, is_load, is_store;
    logic [1:0]    addr_lo;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] load_data;

    assign addr_lo    = ex2mem_alu_out[1:0];
    assign raw_mem_op = ex2mem_valid & (ex2mem_mem_rd | ex2mem_mem_wr) & ~ex2mem_ill_instr;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = raw_mem_op &
                        (((ex2mem_mem_funct3[1:0] == 2'b01) & addr_lo[0]) |
                         ((ex2mem_mem_funct3[1:0] == 2'b10) & (|addr_lo)));
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op   = raw_mem_op & ~misaligned;
    assign is_load  = mem_op & ex2mem_mem_rd;
    assign is_store = mem_op & ~ex2mem_mem_rd & ex2mem_mem_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            off_q      <= '0;
            ld_waddr_q <= '0;
            ld_wen_q   <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            wb_ill_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            ld_waddr_q <= ld_waddr_d;
            ld_wen_q   <= ld_wen_d;
            wb_wen_q   <= wb_wen_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            wb_ill_q   <= wb_ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_load && dmem_ready) state_d = WAIT;
            WAIT:    if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req  = mem_op;
                mem_stall = (mem_op & ~dmem_ready) | (is_load & dmem_ready);
            end
            WAIT:    mem_stall = ~dmem_rvalid;
            default: ;
        endcase
    end

    // Store lanes replicate the data so any byte_en pattern finds it in place.
    always_comb begin
        dmem_write   = is_store;
        dmem_addr    = {ex2mem_alu_out[DW-1:2], 2'b00};
        dmem_byte_en = 4'b1111;
        dmem_wdata   = ex2mem_mem_wdata;
        if (is_store) begin
            case (ex2mem_mem_funct3[1:0])
                2'b00: begin
                    dmem_byte_en = 4'b0001 << addr_lo;
                    dmem_wdata   = {4{ex2mem_mem_wdata[7:0]}};
                end
                2'b01: begin
                    dmem_byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                    dmem_wdata   = {2{ex2mem_mem_wdata[15:0]}};
                end
                default: dmem_byte_en = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_data = dmem_rdata;
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = '0;
        endcase
    end

    // Stalled cycles keep the mem2wb fields but force a bubble via wen=0.
    always_comb begin
        funct3_d   = funct3_q;
        off_d      = off_q;
        ld_waddr_d = ld_waddr_q;
        ld_wen_d   = ld_wen_q;
        wb_wen_d   = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        wb_ill_d   = wb_ill_q;
        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    wb_waddr_d = ex2mem_reg_waddr;
                    wb_wdata_d = ex2mem_alu_out;
                    wb_ill_d   = 1'b1;
                end else if (mem_op) begin
                    if (is_store && dmem_ready) begin
                        wb_waddr_d = ex2mem_reg_waddr;
                        wb_wdata_d = ex2mem_alu_out;
                        wb_ill_d   = 1'b0;
                    end
                    if (is_load && dmem_ready) begin
                        funct3_d   = ex2mem_mem_funct3;
                        off_d      = addr_lo;
                        ld_waddr_d = ex2mem_reg_waddr;
                        ld_wen_d   = ex2mem_reg_wen;
                    end
                end else begin
                    wb_wen_d   = ex2mem_valid & ex2mem_reg_wen & ~ex2mem_ill_instr;
                    wb_waddr_d = ex2mem_reg_waddr;
                    wb_wdata_d = ex2mem_alu_out;
                    wb_ill_d   = ex2mem_valid & ex2mem_ill_instr;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    wb_wen_d   = ld_wen_q;
                    wb_waddr_d = ld_waddr_q;
                    wb_wdata_d = load_data;
                    wb_ill_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem2wb_reg_wen   = wb_wen_q;
    assign mem2wb_reg_waddr = wb_waddr_q;
    assign mem2wb_reg_wdata = wb_wdata_q;
    assign mem2wb_ill_instr = wb_ill_q;

endmodule
